// File: rtl/psu_seq_monitor.sv
// Two-channel power-supply sequencing monitor: decodes thermometer ramps, tracks
// per-channel ramp FSMs, flags protocol errors and counts phase-0 power cycles.
module psu_seq_monitor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH:0]   ctl0,
   input  logic [WIDTH:0]   ctl1,
   input  logic [3:0]       en,
   input  logic             clr,
   output logic [3:0]       level0,
   output logic [3:0]       level1,
   output logic [1:0]       st0,
   output logic [1:0]       st1,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [7:0]       cycles
);

   typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, HIGH = 2'd2, FALL = 2'd3} st_t;

   typedef struct packed {
      st_t        st;
      logic [3:0] lvl;
      logic       e1;
      logic       e2;
      logic       e3;
      logic       done;
   } chan_t;

   localparam logic [3:0] LVL_TOP = 4'(WIDTH + 1);

   st_t            state0, state1;
   logic [WIDTH:0] s_ctl0, s_ctl1;
   logic [3:0]     s_en;
   logic           s_vld, p_vld, chk;
   chan_t          c0, c1;
   logic           e4, e5;
   logic [2:0]     new_code;

   // First valid sample after reset seeds level and state without any checks.
   function automatic chan_t chan_step(input st_t st, input logic [3:0] prev,
                                       input logic [WIDTH:0] smp, input logic chk_en);
      chan_t          r;
      logic [3:0]     lv;
      logic [WIDTH:0] inc;
      r.st   = st;
      r.lvl  = prev;
      r.e1   = 1'b0;
      r.e2   = 1'b0;
      r.e3   = 1'b0;
      r.done = 1'b0;
      lv = '0;
      for (int unsigned i = 0; i <= WIDTH; i++) lv = lv + 4'(smp[i]);
      inc = smp + 1'b1;
      if ((inc & smp) != '0) begin
         r.e1 = chk_en;
      end else if (!chk_en) begin
         r.lvl = lv;
         if (lv == 4'd0)         r.st = IDLE;
         else if (lv == LVL_TOP) r.st = HIGH;
         else                    r.st = RISE;
      end else begin
         r.lvl = lv;
         r.e2  = ({1'b0, lv} > {1'b0, prev} + 5'd1) || ({1'b0, prev} > {1'b0, lv} + 5'd1);
         if (lv != prev) begin
            case (st)
               IDLE: r.st = RISE;
               RISE: begin
                  if (lv < prev) begin
                     r.e3 = 1'b1;
                     r.st = FALL;
                  end else if (lv == LVL_TOP) begin
                     r.st = HIGH;
                  end
               end
               HIGH: r.st = FALL;
               FALL: begin
                  if (lv > prev) begin
                     r.e3 = 1'b1;
                     r.st = RISE;
                  end else if (lv == 4'd0) begin
                     r.st   = IDLE;
                     r.done = 1'b1;
                  end
               end
            endcase
         end
      end
      return r;
   endfunction

   assign chk = s_vld & p_vld;
   assign st0 = state0;
   assign st1 = state1;

   always_comb begin
      c0 = chan_step(state0, level0, s_ctl0, chk);
      c1 = chan_step(state1, level1, s_ctl1, chk);
      e4 = chk & ((s_en & (s_en - 4'd1)) != 4'd0);
      // Busy is judged on the state this sample moves the channels into.
      e5 = chk & (|s_en) & (c0.st == RISE || c0.st == FALL || c1.st == RISE || c1.st == FALL);
      new_code = 3'd0;
      if (c0.e1 || c1.e1)      new_code = 3'd1;
      else if (c0.e2 || c1.e2) new_code = 3'd2;
      else if (c0.e3 || c1.e3) new_code = 3'd3;
      else if (e4)             new_code = 3'd4;
      else if (e5)             new_code = 3'd5;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ctl0   <= '0;
         s_ctl1   <= '0;
         s_en     <= '0;
         s_vld    <= 1'b0;
         p_vld    <= 1'b0;
         level0   <= '0;
         level1   <= '0;
         state0   <= IDLE;
         state1   <= IDLE;
         err      <= 1'b0;
         err_code <= '0;
         cycles   <= '0;
      end else begin
         s_ctl0 <= ctl0;
         s_ctl1 <= ctl1;
         s_en   <= en;
         s_vld  <= 1'b1;
         p_vld  <= s_vld;
         if (s_vld) begin
            level0 <= c0.lvl;
            level1 <= c1.lvl;
            state0 <= c0.st;
            state1 <= c1.st;
         end
         if (clr) begin
            err      <= 1'b0;
            err_code <= '0;
            cycles   <= '0;
         end else begin
            if (!err && new_code != 3'd0) begin
               err      <= 1'b1;
               err_code <= new_code;
            end
            if (c0.done) cycles <= cycles + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_psu_seq_monitor.sv
// Directed scoreboard bench for psu_seq_monitor: expectations are queued with the
// two-edge result latency and compared as each edge retires them.
module tb_psu_seq_monitor;

   localparam int F_L0 = 0, F_L1 = 1, F_S0 = 2, F_S1 = 3, F_ERR = 4, F_CODE = 5, F_CYC = 6;
   localparam int IDLE = 0, RISE = 1, HIGH = 2, FALL = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] ctl0 = '0, ctl1 = '0;
   logic [3:0] en = '0;
   logic       clr = 1'b0;
   logic [3:0] level0, level1;
   logic [1:0] st0, st1;
   logic       err;
   logic [2:0] err_code;
   logic [7:0] cycles;

   typedef struct {
      int    due;
      int    fld;
      int    val;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   psu_seq_monitor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .ctl0(ctl0), .ctl1(ctl1), .en(en), .clr(clr),
      .level0(level0), .level1(level1), .st0(st0), .st1(st1),
      .err(err), .err_code(err_code), .cycles(cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] obs(input int f);
      case (f)
         F_L0:    return 32'(level0);
         F_L1:    return 32'(level1);
         F_S0:    return 32'(st0);
         F_S1:    return 32'(st1);
         F_ERR:   return 32'(err);
         F_CODE:  return 32'(err_code);
         default: return 32'(cycles);
      endcase
   endfunction

   function automatic logic [8:0] therm(input int n);
      int x;
      x = (1 << n) - 1;
      return 9'(x);
   endfunction

   task automatic check_now(input string tag, input int f, input int val);
      logic [31:0] got;
      got = obs(f);
      vectors++;
      assert (got === 32'(val)) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, val, cyc);
      end
   endtask

   task automatic expect2(input string tag, input int f, input int val);
      exp_t e;
      e.due = cyc + 2;
      e.fld = f;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check_now(e.tag, e.fld, e.val);
      end
   endtask

   task automatic settle();
      tick();
      tick();
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_now("clr_err", F_ERR, 0);
      check_now("clr_code", F_CODE, 0);
      check_now("clr_cyc", F_CYC, 0);
   endtask

   task automatic ramp_cycle();
      for (int i = 1; i <= 9; i++) begin
         ctl0 = therm(i);
         tick();
      end
      for (int i = 8; i >= 0; i--) begin
         ctl0 = therm(i);
         tick();
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      for (int f = 0; f <= 6; f++) check_now("rst_init", f, 0);
      rst = 1'b0;
      repeat (4) tick();

      // Full phase-0 power cycle with enable only while fully up
      for (int i = 1; i <= 9; i++) begin
         ctl0 = therm(i);
         en   = (i == 9) ? 4'b0001 : 4'b0000;
         expect2("up_lvl", F_L0, i);
         expect2("up_st", F_S0, (i == 9) ? HIGH : RISE);
         tick();
      end
      repeat (3) begin
         expect2("hold_st", F_S0, HIGH);
         expect2("hold_err", F_ERR, 0);
         tick();
      end
      en = 4'b0000;
      for (int i = 8; i >= 0; i--) begin
         ctl0 = therm(i);
         expect2("dn_lvl", F_L0, i);
         expect2("dn_st", F_S0, (i == 0) ? IDLE : FALL);
         tick();
      end
      settle();
      check_now("cyc1_cnt", F_CYC, 1);
      check_now("cyc1_err", F_ERR, 0);

      // Step of two levels
      ctl0 = 9'h001; tick();
      ctl0 = 9'h003; expect2("step_pre_err", F_ERR, 0); expect2("step_pre_lvl", F_L0, 2); tick();
      ctl0 = 9'h00F;
      expect2("step_err", F_ERR, 1);
      expect2("step_code", F_CODE, 2);
      expect2("step_lvl", F_L0, 4);
      expect2("step_st", F_S0, RISE);
      tick();
      ctl0 = 9'h007; expect2("rev_st", F_S0, FALL); expect2("rev_code", F_CODE, 2); tick();
      ctl0 = 9'h003; tick();
      ctl0 = 9'h001; tick();
      ctl0 = 9'h000; expect2("rev_idle", F_S0, IDLE); expect2("rev_cyc", F_CYC, 2); tick();
      settle();
      clr_pulse();

      // Non-thermometer sample on phase 1 with simultaneous multi-enable
      ctl1 = 9'h001; tick();
      ctl1 = 9'h003; expect2("p1_lvl", F_L1, 2); expect2("p1_st", F_S1, RISE); tick();
      ctl1 = 9'h005; en = 4'b0011;
      expect2("nt_err", F_ERR, 1);
      expect2("nt_code", F_CODE, 1);
      expect2("nt_lvl", F_L1, 2);
      expect2("nt_st", F_S1, RISE);
      tick();
      en = 4'b0000;
      ctl1 = 9'h003; tick();
      ctl1 = 9'h001; expect2("p1_fall", F_S1, FALL); tick();
      ctl1 = 9'h000; expect2("p1_idle", F_S1, IDLE); expect2("p1_cyc", F_CYC, 0); tick();
      settle();
      check_now("p1_code_kept", F_CODE, 1);
      clr_pulse();

      // Enable during a ramp, then a later step error must not overwrite
      ctl0 = 9'h001; tick();
      ctl0 = 9'h003; tick();
      ctl0 = 9'h007; en = 4'b0100;
      expect2("busy_err", F_ERR, 1);
      expect2("busy_code", F_CODE, 5);
      expect2("busy_lvl", F_L0, 3);
      tick();
      en = 4'b0000;
      ctl0 = 9'h07F; expect2("sticky_code", F_CODE, 5); expect2("sticky_lvl", F_L0, 7); tick();
      for (int i = 6; i >= 0; i--) begin
         ctl0 = therm(i);
         tick();
      end
      settle();
      check_now("busy_idle", F_S0, IDLE);
      check_now("busy_cyc", F_CYC, 1);
      check_now("busy_code_end", F_CODE, 5);
      clr_pulse();

      // Counter wrap and clr racing an increment
      repeat (255) ramp_cycle();
      tick();
      check_now("cyc_255", F_CYC, 255);
      check_now("cyc_255_err", F_ERR, 0);
      ramp_cycle();
      tick();
      check_now("cyc_wrap", F_CYC, 0);
      ramp_cycle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_now("clr_race_cyc", F_CYC, 0);
      check_now("clr_race_st", F_S0, IDLE);
      settle();
      check_now("clr_race_hold", F_CYC, 0);

      // Reset mid-ramp
      for (int i = 1; i <= 5; i++) begin
         ctl0 = therm(i);
         tick();
      end
      settle();
      check_now("mid_pre_lvl", F_L0, 5);
      rst = 1'b1;
      #1;
      for (int f = 0; f <= 6; f++) check_now("mid_rst", f, 0);
      tick();
      check_now("mid_rst_hold", F_L0, 0);
      rst = 1'b0;
      expect2("mid_lvl", F_L0, 5);
      expect2("mid_st", F_S0, RISE);
      tick();
      expect2("mid_err", F_ERR, 0);
      expect2("mid_code", F_CODE, 0);
      tick();
      settle();

      for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
      if (sb.size() > 0) begin
         miscompares++;
         $error("FAIL drain: observed %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/psu_seq_monitor.md
PSU_SEQ_MONITOR -- requirements
Module: psu_seq_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8; each control bus is WIDTH+1 bits wide.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ctl0  input  WIDTH+1  phase-0 supply ramp, thermometer code (bit0 fills first).
REQ-005 ctl1  input  WIDTH+1  phase-1 supply ramp, same encoding.
REQ-006 en  input  4  read/write enables {r3_w1_en, r2_w0_en, r1_w3_en, r0_w2_en}, bit0 = r0_w2_en.
REQ-007 clr  input  1  synchronous clear of error and counter state, active-high.
REQ-008 level0, level1  output  4 each  registered decoded ramp level, 0..WIDTH+1.
REQ-009 st0, st1  output  2 each  channel FSM state: 0 IDLE, 1 RISE, 2 HIGH, 3 FALL.
REQ-010 err  output  1  sticky error flag.
REQ-011 err_code  output  3  code of the first error since reset/clr; 0 = none.
REQ-012 cycles  output  8  count of completed phase-0 power cycles.

Function
REQ-013 Stage 1 SHALL register ctl0, ctl1 and en every cycle; all checks SHALL compare the stage-1 sample against the previous stage-1 sample.
REQ-014 Results of checks SHALL register on the next edge: err rises on the second rising edge after the offending input is first presented.
REQ-015 Level SHALL equal the number of ones in a valid thermometer code; a non-thermometer sample SHALL flag code 1 and hold the previous level.
REQ-016 Per channel, a level step of magnitude >1 between consecutive samples SHALL flag code 2.
REQ-017 Channel FSM: IDLE -> RISE on level 1; RISE -> HIGH on level WIDTH+1; HIGH -> FALL on level WIDTH; FALL -> IDLE on level 0.
REQ-018 A level decrease in RISE or increase in FALL SHALL flag code 3; the FSM SHALL then go to FALL or RISE respectively.
REQ-019 An unchanged level SHALL keep the FSM state in every state.
REQ-020 More than one en bit set in a sample SHALL flag code 4.
REQ-021 Any en bit set while either channel is in RISE or FALL SHALL flag code 5.
REQ-022 When several errors occur in one cycle, err_code SHALL take the lowest code.
REQ-023 err_code SHALL latch only when err is 0; later errors SHALL not overwrite it.
REQ-024 cycles SHALL increment on each phase-0 FALL -> IDLE transition, wrapping 255 -> 0.
REQ-025 clr SHALL zero err, err_code and cycles on the next edge, taking priority over same-cycle increments and errors; FSMs and levels SHALL be unaffected.
REQ-026 Checks SHALL be suppressed on the first sample after reset (no valid previous sample).

Reset
REQ-027 While rst is high: level0/1 = 0, st0/1 = IDLE, err = 0, err_code = 0, cycles = 0, stage-1 samples = 0.
REQ-028 Reset asserted mid-ramp SHALL abort all state immediately; after release, the first sample SHALL initialise silently per REQ-026.

Verification
REQ-029 Ramp ctl0 0x000 -> 0x1FF one bit per cycle, hold 3, ramp down, en = 0001 only while ctl0 = 0x1FF -> st0 visits IDLE, RISE, HIGH, FALL, IDLE; cycles = 1; err = 0.
REQ-030 ctl0 = 0x003 then 0x00F -> err = 1, err_code = 2 on the second edge after 0x00F; level0 = 4.
REQ-031 ctl1 = 0x005 -> err_code = 1; level1 unchanged; a simultaneous en = 0011 still reports code 1.
REQ-032 ctl0 at level 3 (RISE) with en = 0100 -> err_code = 5; later code 2 event leaves err_code = 5.
REQ-033 256 full phase-0 cycles -> cycles = 0; clr coincident with a FALL -> IDLE edge -> cycles = 0.
REQ-034 rst pulsed while ctl0 = 0x01F in RISE, ctl0 held -> all outputs 0 during rst; after release level0 = 5, st0 = RISE, no error flagged.
